// File: rtl/nonce_dispatch_scheduler.sv
// Round-robin nonce dispatcher and result collector for a pool of SHA-256 double-hash engines.
// Define SCHED_PERF_CNT_EN to add the hash_cnt result counter output.
module nonce_dispatch_scheduler #(
   parameter int NUM_ENG = 4,
   parameter int IDX_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            nonce_base,
   input  logic [31:0]            nonce_count,
   input  logic [31:0]            target,
   input  logic                   abort,
   input  logic [NUM_ENG-1:0]     eng_ready,
   output logic [NUM_ENG-1:0]     eng_start,
   output logic [31:0]            eng_nonce,
   input  logic [NUM_ENG-1:0]     eng_done,
   input  logic [32*NUM_ENG-1:0]  eng_hash,
   output logic [NUM_ENG-1:0]     eng_ack,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [31:0]            found_nonce,
   output logic [31:0]            found_hash
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]            hash_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_FINISH} state_t;

   state_t               state_q;
   logic [31:0]          next_nonce_q;
   logic [31:0]          remain_q;
   logic [31:0]          target_q;
   logic [IDX_W-1:0]     disp_ptr_q;
   logic [IDX_W-1:0]     coll_ptr_q;
   logic [NUM_ENG-1:0]   inflight_q;
   logic [NUM_ENG-1:0]   eng_start_q;
   logic [NUM_ENG-1:0]   eng_ack_q;
   logic [31:0]          eng_nonce_q;
   logic [31:0]          nonce_mem_q [NUM_ENG];
   logic                 busy_q;
   logic                 done_q;
   logic                 found_q;
   logic [31:0]          found_nonce_q;
   logic [31:0]          found_hash_q;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0]          hash_cnt_q;
`endif

   logic [31:0]          hash_w [NUM_ENG];
   logic [NUM_ENG-1:0]   disp_cand;
   logic [NUM_ENG-1:0]   coll_cand;
   logic                 disp_vld;
   logic [IDX_W-1:0]     disp_idx;
   logic                 coll_vld;
   logic [IDX_W-1:0]     coll_idx;
   logic [31:0]          nonce_cur;
   logic [31:0]          remain_cur;
   logic                 accept;
   logic                 coll_active;
   logic                 win;
   logic                 disp_go;
   logic [NUM_ENG-1:0]   disp_mask;
   logic [NUM_ENG-1:0]   ack_mask;

   for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_hash
      assign hash_w[gi] = eng_hash[32*gi +: 32];
   end

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
      int s;
      s = int'(ptr) + k;
      if (s >= NUM_ENG) s = s - NUM_ENG;
      return IDX_W'(s);
   endfunction

   function automatic logic [NUM_ENG-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_ENG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign disp_cand = eng_ready & ~inflight_q;
   assign coll_cand = eng_done & inflight_q;

   // Scan from the farthest offset down so the nearest candidate to the pointer wins.
   always_comb begin
      disp_vld = 1'b0;
      disp_idx = '0;
      coll_vld = 1'b0;
      coll_idx = '0;
      for (int k = NUM_ENG - 1; k >= 0; k--) begin
         if (disp_cand[rr_idx(disp_ptr_q, k)]) begin
            disp_vld = 1'b1;
            disp_idx = rr_idx(disp_ptr_q, k);
         end
         if (coll_cand[rr_idx(coll_ptr_q, k)]) begin
            coll_vld = 1'b1;
            coll_idx = rr_idx(coll_ptr_q, k);
         end
      end
   end

   // The accepting edge already dispatches from nonce_base so the first job leaves one cycle after start.
   assign accept      = (state_q == S_IDLE) && start;
   assign nonce_cur   = (state_q == S_IDLE) ? nonce_base : next_nonce_q;
   assign remain_cur  = (state_q == S_IDLE) ? nonce_count : remain_q;
   assign coll_active = coll_vld && ((state_q == S_DISPATCH) || (state_q == S_DRAIN));
   assign win         = coll_active && (state_q == S_DISPATCH) && !found_q &&
                        (hash_w[coll_idx] < target_q);
   assign disp_go     = disp_vld &&
                        ((accept && (nonce_count != 32'd0)) ||
                         ((state_q == S_DISPATCH) && (remain_q != 32'd0) && !found_q && !abort && !win));
   assign disp_mask   = disp_go ? onehot(disp_idx) : '0;
   assign ack_mask    = coll_active ? onehot(coll_idx) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         next_nonce_q  <= '0;
         remain_q      <= '0;
         target_q      <= '0;
         disp_ptr_q    <= '0;
         coll_ptr_q    <= '0;
         inflight_q    <= '0;
         eng_start_q   <= '0;
         eng_ack_q     <= '0;
         eng_nonce_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         found_q       <= 1'b0;
         found_nonce_q <= '0;
         found_hash_q  <= '0;
`ifdef SCHED_PERF_CNT_EN
         hash_cnt_q    <= '0;
`endif
      end else begin
         eng_start_q <= disp_mask;
         eng_ack_q   <= ack_mask;
         done_q      <= 1'b0;
         inflight_q  <= (inflight_q & ~ack_mask) | disp_mask;

         if (disp_go) begin
            eng_nonce_q            <= nonce_cur;
            nonce_mem_q[disp_idx]  <= nonce_cur;
            next_nonce_q           <= nonce_cur + 32'd1;
            remain_q               <= remain_cur - 32'd1;
            disp_ptr_q             <= rr_idx(disp_idx, 1);
         end

         if (coll_active) begin
            coll_ptr_q <= rr_idx(coll_idx, 1);
`ifdef SCHED_PERF_CNT_EN
            hash_cnt_q <= hash_cnt_q + 32'd1;
`endif
         end

         if (win) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce_mem_q[coll_idx];
            found_hash_q  <= hash_w[coll_idx];
         end

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q        <= 1'b1;
                  found_q       <= 1'b0;
                  found_nonce_q <= '0;
                  found_hash_q  <= '0;
                  target_q      <= target;
`ifdef SCHED_PERF_CNT_EN
                  hash_cnt_q    <= '0;
`endif
                  if (!disp_go) begin
                     next_nonce_q <= nonce_base;
                     remain_q     <= nonce_count;
                  end
                  state_q <= (nonce_count == 32'd0) ? S_FINISH : S_DISPATCH;
               end
            end
            S_DISPATCH: begin
               if ((remain_q == 32'd0) || found_q || win || abort) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (inflight_q == '0) state_q <= S_FINISH;
            end
            S_FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign eng_start   = eng_start_q;
   assign eng_ack     = eng_ack_q;
   assign eng_nonce   = eng_nonce_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign found_nonce = found_nonce_q;
   assign found_hash  = found_hash_q;
`ifdef SCHED_PERF_CNT_EN
   assign hash_cnt    = hash_cnt_q;
`endif

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// Scoreboard bench for nonce_dispatch_scheduler with a behavioural engine pool model.
// Honours SCHED_PERF_CNT_EN when defined.
module tb_nonce_dispatch_scheduler;
   localparam int NUM_ENG = 4;
   localparam int IDX_W   = 2;
   localparam int LAT     = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [31:0]           nonce_base;
   logic [31:0]           nonce_count;
   logic [31:0]           target;
   logic                  abort;
   logic [NUM_ENG-1:0]    eng_ready;
   logic [NUM_ENG-1:0]    eng_start;
   logic [31:0]           eng_nonce;
   logic [NUM_ENG-1:0]    eng_done;
   logic [32*NUM_ENG-1:0] eng_hash;
   logic [NUM_ENG-1:0]    eng_ack;
   logic                  busy;
   logic                  done;
   logic                  found;
   logic [31:0]           found_nonce;
   logic [31:0]           found_hash;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0]           hash_cnt;
`endif

   nonce_dispatch_scheduler #(.NUM_ENG(NUM_ENG), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .start(start), .nonce_base(nonce_base),
      .nonce_count(nonce_count), .target(target), .abort(abort),
      .eng_ready(eng_ready), .eng_start(eng_start), .eng_nonce(eng_nonce),
      .eng_done(eng_done), .eng_hash(eng_hash), .eng_ack(eng_ack),
      .busy(busy), .done(done), .found(found),
      .found_nonce(found_nonce), .found_hash(found_hash)
`ifdef SCHED_PERF_CNT_EN
      , .hash_cnt(hash_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Engine pool model: takes a job on eng_start, computes for LAT cycles, holds the
   // result until acked. gate=0 withholds eng_done so results can be released together.
   logic               gate;
   logic [31:0]        win_nonce;
   logic [NUM_ENG-1:0] e_pend;
   logic [NUM_ENG-1:0] e_busy;
   int                 e_cnt   [NUM_ENG];
   logic [31:0]        e_nonce [NUM_ENG];
   logic [31:0]        e_hash  [NUM_ENG];

   assign eng_done = e_pend & {NUM_ENG{gate}};
   always_comb begin
      for (int i = 0; i < NUM_ENG; i++) eng_hash[32*i +: 32] = e_hash[i];
   end

   always @(negedge clk) begin
      for (int i = 0; i < NUM_ENG; i++) begin
         if (reset) begin
            eng_ready[i] = 1'b1;
            e_pend[i]    = 1'b0;
            e_busy[i]    = 1'b0;
            e_cnt[i]     = 0;
            e_nonce[i]   = 32'h0;
            e_hash[i]    = 32'hFFFF_FFFF;
         end else begin
            if (eng_ack[i]) begin
               e_pend[i]    = 1'b0;
               eng_ready[i] = 1'b1;
            end
            if (e_busy[i]) begin
               if (e_cnt[i] == 0) begin
                  e_busy[i] = 1'b0;
                  e_pend[i] = 1'b1;
                  e_hash[i] = (e_nonce[i] == win_nonce) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
               end else begin
                  e_cnt[i] = e_cnt[i] - 1;
               end
            end
            if (eng_start[i]) begin
               eng_ready[i] = 1'b0;
               e_busy[i]    = 1'b1;
               e_cnt[i]     = LAT - 1;
               e_nonce[i]   = eng_nonce;
            end
         end
      end
   end

   typedef struct {
      int          eng;
      logic [31:0] nonce;
   } disp_t;

   typedef struct {
      int eng;
      bit consec;
   } ack_t;

   typedef struct {
      logic        found;
      logic [31:0] nonce;
      logic [31:0] hash;
      int          lat;
      int          first_lat;
      int          cnt;
   } done_t;

   disp_t exp_disp[$];
   ack_t  exp_ack[$];
   done_t exp_done[$];

   int start_cyc;
   int first_disp_cyc;
   int last_ack_cyc;
   int run_disp;
   int run_ack;
   int done_cnt = 0;
   bit abort_block;

   function automatic int idx_of(input logic [NUM_ENG-1:0] v);
      for (int i = 0; i < NUM_ENG; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Monitor: samples 1 time unit after each rising edge and checks against the queues.
   always begin
      @(posedge clk);
      #1;
      if (!reset) begin
         if (eng_start != '0) begin
            disp_t d;
            run_disp++;
            if (first_disp_cyc < 0) first_disp_cyc = cyc;
            $display("[TB] dispatch eng=%0d nonce=0x%08h cyc=%0d", idx_of(eng_start), eng_nonce, cyc);
            check("disp_onehot", 32'($onehot(eng_start)), 32'd1);
            check("disp_busy", 32'(busy), 32'd1);
            check("disp_after_win", 32'(found), 32'd0);
            check("disp_after_abort", 32'(abort_block), 32'd0);
            if (exp_disp.size() == 0) begin
               check("disp_unexpected", 32'(eng_start), 32'd0);
            end else begin
               d = exp_disp.pop_front();
               check("disp_nonce", eng_nonce, d.nonce);
               if (d.eng >= 0) check("disp_engine", 32'(idx_of(eng_start)), 32'(d.eng));
            end
         end
         if (eng_ack != '0) begin
            ack_t a;
            run_ack++;
            check("ack_onehot", 32'($onehot(eng_ack)), 32'd1);
            if (exp_ack.size() != 0) begin
               a = exp_ack.pop_front();
               $display("[TB] ack eng=%0d cyc=%0d", idx_of(eng_ack), cyc);
               check("ack_engine", 32'(idx_of(eng_ack)), 32'(a.eng));
               if (a.consec) check("ack_consecutive", 32'(cyc - last_ack_cyc), 32'd1);
            end
            last_ack_cyc = cyc;
         end
         if (done) begin
            done_t e;
            done_cnt++;
            $display("[TB] done found=%0d nonce=0x%08h hash=0x%08h cyc=%0d", found, found_nonce, found_hash, cyc);
            if (exp_done.size() == 0) begin
               check("done_unexpected", 32'(done), 32'd0);
            end else begin
               e = exp_done.pop_front();
               check("done_found", 32'(found), 32'(e.found));
               if (e.found) begin
                  check("found_nonce", found_nonce, e.nonce);
                  check("found_hash", found_hash, e.hash);
               end
               if (e.lat >= 0) check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
               if (e.first_lat >= 0) check("first_disp_latency", 32'(first_disp_cyc - start_cyc), 32'(e.first_lat));
               check("acks_eq_dispatches", 32'(run_ack), 32'(run_disp));
`ifdef SCHED_PERF_CNT_EN
               if (e.cnt >= 0) check("hash_cnt", hash_cnt, 32'(e.cnt));
`endif
            end
         end
      end
   end

   task automatic flush();
      exp_disp.delete();
      exp_ack.delete();
      exp_done.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      gate  = 1'b1;
      flush();
   endtask

   task automatic push_disp(input logic [31:0] base, input int n, input bit rr);
      for (int i = 0; i < n; i++) exp_disp.push_back('{eng: (rr ? i % NUM_ENG : -1), nonce: base + 32'(i)});
   endtask

   task automatic push_done(input logic f, input logic [31:0] n, input logic [31:0] h,
                            input int lat, input int first_lat, input int cnt);
      exp_done.push_back('{found: f, nonce: n, hash: h, lat: lat, first_lat: first_lat, cnt: cnt});
   endtask

   task automatic run_start(input logic [31:0] base, input logic [31:0] count, input logic [31:0] tgt);
      @(negedge clk);
      nonce_base     = base;
      nonce_count    = count;
      target         = tgt;
      run_disp       = 0;
      run_ack        = 0;
      first_disp_cyc = -1;
      last_ack_cyc   = 0;
      abort_block    = 1'b0;
      start_cyc      = cyc;
      start          = 1'b1;
      @(negedge clk);
      start          = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0;
      bit ok;
      d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_eng_start"}, 32'(eng_start), 32'd0);
      check({name, "_eng_ack"}, 32'(eng_ack), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_done"}, 32'(done), 32'd0);
      check({name, "_found"}, 32'(found), 32'd0);
      check({name, "_eng_nonce"}, eng_nonce, 32'd0);
      check({name, "_found_nonce"}, found_nonce, 32'd0);
      check({name, "_found_hash"}, found_hash, 32'd0);
`ifdef SCHED_PERF_CNT_EN
      check({name, "_hash_cnt"}, hash_cnt, 32'd0);
`endif
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      nonce_base  = '0;
      nonce_count = '0;
      target      = '0;
      gate        = 1'b1;
      win_nonce   = 32'hDEAD_BEEF;
      abort_block = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset");

      // T1: empty range finishes two cycles after start without dispatching
      push_done(1'b0, 32'h0, 32'h0, 2, -1, 0);
      run_start(32'h0000_1234, 32'd0, 32'h0);
      wait_done("t1_done_timeout", 20);

      // T2: eight nonces round-robin over all four engines, no winner possible
      do_reset();
      push_disp(32'h10, 8, 1'b1);
      push_done(1'b0, 32'h0, 32'h0, -1, 1, 8);
      run_start(32'h10, 32'd8, 32'h0);
      wait_done("t2_done_timeout", 200);
      check("t2_all_issued", 32'(exp_disp.size()), 32'd0);

      // T3: single winner at 0x105
      do_reset();
      win_nonce = 32'h0000_0105;
      push_disp(32'h100, 16, 1'b0);
      push_done(1'b1, 32'h0000_0105, 32'h7FFF_FFFF, -1, 1, -1);
      run_start(32'h100, 32'd16, 32'h8000_0000);
      wait_done("t3_done_timeout", 300);
      repeat (3) @(negedge clk);
      check("t3_found_held", 32'(found), 32'd1);
      check("t3_found_nonce_held", found_nonce, 32'h0000_0105);
      win_nonce = 32'hDEAD_BEEF;

      // T4: nonce counter wraps through zero
      do_reset();
      push_disp(32'hFFFF_FFFE, 4, 1'b1);
      push_done(1'b0, 32'h0, 32'h0, -1, 1, 4);
      run_start(32'hFFFF_FFFE, 32'd4, 32'h0);
      wait_done("t4_done_timeout", 100);
      check("t4_all_issued", 32'(exp_disp.size()), 32'd0);

      // T5a: four results released together are acked on consecutive cycles 0,1,2,3
      do_reset();
      gate = 1'b0;
      push_disp(32'h300, 4, 1'b1);
      exp_ack.push_back('{eng: 0, consec: 1'b0});
      exp_ack.push_back('{eng: 1, consec: 1'b1});
      exp_ack.push_back('{eng: 2, consec: 1'b1});
      exp_ack.push_back('{eng: 3, consec: 1'b1});
      push_done(1'b0, 32'h0, 32'h0, -1, 1, 4);
      run_start(32'h300, 32'd4, 32'h0);
      repeat (12) @(negedge clk);
      gate = 1'b1;
      wait_done("t5a_done_timeout", 100);
      check("t5a_all_acked", 32'(exp_ack.size()), 32'd0);

      // T5b: abort mid-run stops dispatch and drains
      do_reset();
      push_disp(32'h2000, 100, 1'b0);
      push_done(1'b0, 32'h0, 32'h0, -1, 1, -1);
      run_start(32'h2000, 32'd100, 32'h0);
      repeat (6) @(negedge clk);
      abort       = 1'b1;
      abort_block = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("t5b_done_timeout", 100);

      // T6: reset mid-dispatch, then a fresh run
      do_reset();
      push_disp(32'h400, 50, 1'b0);
      run_start(32'h400, 32'd50, 32'h0);
      repeat (5) @(negedge clk);
      check("t6_busy_before_reset", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_zero_outputs("t6_reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      flush();
      push_disp(32'h500, 4, 1'b1);
      push_done(1'b0, 32'h0, 32'h0, -1, 1, 4);
      run_start(32'h500, 32'd4, 32'h0);
      wait_done("t6_done_timeout", 100);
      check("t6_all_issued", 32'(exp_disp.size()), 32'd0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
